// File: rtl/uart_img_pkg.sv
// Shared constants for the UART image sender/receiver pair: image size, bit timing, FSM encoding.
package uart_img_pkg;

  localparam int IMG_BYTES_DEF = 784;
  localparam int ADDR_W        = 10;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RECV = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic int bit_cyc(input int clk_freq, input int bps);
    return clk_freq / bps;
  endfunction

endpackage

// File: rtl/uart_recv.sv
// UART 8N1 receiver: 2-FF synchronizer, start-bit qualification at half bit, centre sampling.
// rx_valid / rx_frame_err are 1-cycle pulses at the stop-bit centre.
module uart_recv #(
  parameter int BIT_CYC = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       rx_frame_err
);

  localparam int CW = $clog2(BIT_CYC + 1);
  localparam logic [CW-1:0] FULL = CW'(BIT_CYC - 1);
  localparam logic [CW-1:0] HALF = CW'(BIT_CYC / 2 - 1);

  localparam logic [2:0] RX_IDLE  = 3'd0;
  localparam logic [2:0] RX_START = 3'd1;
  localparam logic [2:0] RX_DATA  = 3'd2;
  localparam logic [2:0] RX_STOP  = 3'd3;
  localparam logic [2:0] RX_WAITH = 3'd4;

  logic          sync1_q, sync2_q, prev_q;
  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (prev_q && !sync2_q) state_d = RX_START;
      end
      RX_START: begin
        // A start bit that is high again at half-bit was only a glitch.
        if (cnt_q == HALF) begin
          cnt_d = '0;
          if (sync2_q) begin
            state_d = RX_IDLE;
          end else begin
            state_d = RX_DATA;
            bit_d   = 3'd0;
          end
        end
      end
      RX_DATA: begin
        if (cnt_q == FULL) begin
          cnt_d   = '0;
          shift_d = {sync2_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt_q == FULL) begin
          cnt_d = '0;
          if (sync2_q) begin
            valid_d = 1'b1;
            state_d = RX_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = RX_WAITH;
          end
        end
      end
      RX_WAITH: begin
        cnt_d = '0;
        if (sync2_q) state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'd0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync1_q <= rxd;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  assign rx_valid     = valid_q;
  assign rx_data      = shift_q;
  assign rx_frame_err = ferr_q;

endmodule

// File: rtl/uart_img_recv.sv
// Receives one image over UART and writes it byte by byte to the image RAM from address 0.
// RAM write is registered: ram_we the cycle after the byte's stop-bit centre; done one cycle later.
module uart_img_recv
  import uart_img_pkg::*;
#(
  parameter int CLK_FREQ    = 50000000,
  parameter int UART_BPS    = 115200,
  parameter int IMG_BYTES   = IMG_BYTES_DEF,
  parameter int TIMEOUT_CYC = 5000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              uart_rxd,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  output logic              busy,
  output logic              done,
  output logic              err_timeout,
  output logic              err_frame
);

  localparam int BIT_CYC = bit_cyc(CLK_FREQ, UART_BPS);
  localparam int TW      = $clog2(TIMEOUT_CYC + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_BYTES - 1);
  localparam logic [TW-1:0]     TO_MAX    = TW'(TIMEOUT_CYC);

  logic       rx_valid, rx_frame_err;
  logic [7:0] rx_data;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [TW-1:0]     to_cnt_q, to_cnt_d;
  logic              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [7:0]        ram_wdata_q, ram_wdata_d;
  logic              done_q, done_d;
  logic              err_timeout_q, err_timeout_d;
  logic              err_frame_q, err_frame_d;

  uart_recv #(.BIT_CYC(BIT_CYC)) u_recv (
    .clk          (clk),
    .rst          (rst),
    .rxd          (uart_rxd),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .rx_frame_err (rx_frame_err)
  );

  always_comb begin
    state_d       = state_q;
    byte_cnt_d    = byte_cnt_q;
    to_cnt_d      = to_cnt_q;
    ram_we_d      = 1'b0;
    ram_addr_d    = ram_addr_q;
    ram_wdata_d   = ram_wdata_q;
    done_d        = 1'b0;
    err_timeout_d = err_timeout_q;
    err_frame_d   = err_frame_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d       = ST_RECV;
          byte_cnt_d    = '0;
          to_cnt_d      = '0;
          err_timeout_d = 1'b0;
          err_frame_d   = 1'b0;
        end
      end
      ST_RECV: begin
        // A byte landing on the expiry cycle takes priority over the timeout.
        if (rx_valid) begin
          ram_we_d    = 1'b1;
          ram_addr_d  = byte_cnt_q;
          ram_wdata_d = rx_data;
          byte_cnt_d  = byte_cnt_q + ADDR_W'(1);
          to_cnt_d    = '0;
          if (byte_cnt_q == LAST_ADDR) state_d = ST_DONE;
        end else begin
          if (rx_frame_err) err_frame_d = 1'b1;
          if (to_cnt_q == TO_MAX) begin
            state_d       = ST_IDLE;
            err_timeout_d = 1'b1;
          end else begin
            to_cnt_d = to_cnt_q + TW'(1);
          end
        end
      end
      ST_DONE: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      byte_cnt_q    <= '0;
      to_cnt_q      <= '0;
      ram_we_q      <= 1'b0;
      ram_addr_q    <= '0;
      ram_wdata_q   <= 8'd0;
      done_q        <= 1'b0;
      err_timeout_q <= 1'b0;
      err_frame_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      byte_cnt_q    <= byte_cnt_d;
      to_cnt_q      <= to_cnt_d;
      ram_we_q      <= ram_we_d;
      ram_addr_q    <= ram_addr_d;
      ram_wdata_q   <= ram_wdata_d;
      done_q        <= done_d;
      err_timeout_q <= err_timeout_d;
      err_frame_q   <= err_frame_d;
    end
  end

  assign ram_we      = ram_we_q;
  assign ram_addr    = ram_addr_q;
  assign ram_wdata   = ram_wdata_q;
  assign busy        = (state_q == ST_RECV);
  assign done        = done_q;
  assign err_timeout = err_timeout_q;
  assign err_frame   = err_frame_q;

endmodule

// File: tb/tb_uart_img_recv.sv
// Bench for uart_img_recv with scaled timing: 16 clocks per bit, 32-byte image, 2000-clock timeout.
module tb_uart_img_recv;

  localparam int CLK_FREQ = 1600000;
  localparam int UART_BPS = 100000;
  localparam int BIT      = CLK_FREQ / UART_BPS;
  localparam int IMG      = 32;
  localparam int TIMEOUT  = 2000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       uart_rxd = 1'b1;
  logic       ram_we;
  logic [9:0] ram_addr;
  logic [7:0] ram_wdata;
  logic       busy, done, err_timeout, err_frame;

  int n_pass = 0;
  int n_total = 0;

  uart_img_recv #(
    .CLK_FREQ(CLK_FREQ), .UART_BPS(UART_BPS), .IMG_BYTES(IMG), .TIMEOUT_CYC(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .uart_rxd(uart_rxd),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .busy(busy), .done(done), .err_timeout(err_timeout), .err_frame(err_frame)
  );

  always #5 clk = ~clk;

  // Observed RAM writes and done pulses
  int         cyc = 0;
  logic [9:0] obs_addr[$];
  logic [7:0] obs_data[$];
  int         done_cnt = 0;
  int         done_cyc = 0;
  int         last_we_cyc = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (ram_we) begin
      obs_addr.push_back(ram_addr);
      obs_data.push_back(ram_wdata);
      last_we_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  // Reference model: while armed, each good-stop byte lands at the next address from 0.
  logic [9:0] exp_addr[$];
  logic [7:0] exp_data[$];
  bit         m_armed = 1'b0;
  int         m_cnt = 0;
  int         obs_base = 0;
  int         done_base = 0;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1, "watchdog");
  end

  task automatic drive_bit(input logic v);
    uart_rxd = v;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop);
    uart_rxd = 1'b1;
    if (stop && m_armed) begin
      exp_addr.push_back(10'(m_cnt));
      exp_data.push_back(b);
      m_cnt++;
      if (m_cnt == IMG) m_armed = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    uart_rxd = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic arm();
    exp_addr.delete();
    exp_data.delete();
    m_cnt     = 0;
    m_armed   = 1'b1;
    obs_base  = obs_addr.size();
    done_base = done_cnt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_timeout();
    idle(TIMEOUT + 60);
    m_armed = 1'b0;
  endtask

  task automatic wait_done();
    for (int k = 0; k < 200 && done_cnt == done_base; k++) @(negedge clk);
    repeat (4) @(negedge clk);
  endtask

  function automatic int n_writes();
    return obs_addr.size() - obs_base;
  endfunction

  function automatic int img_mismatch();
    int m = 0;
    if (n_writes() != exp_addr.size()) return -1;
    for (int k = 0; k < exp_addr.size(); k++)
      if (obs_addr[obs_base + k] !== exp_addr[k] || obs_data[obs_base + k] !== exp_data[k]) m++;
    return m;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    #1;
    n_total++;
    if ({ram_we, ram_addr, ram_wdata, busy, done, err_timeout, err_frame} !== 23'd0)
      $display("FAIL reset_outputs: got %b required all 0",
               {ram_we, ram_addr, ram_wdata, busy, done, err_timeout, err_frame});
    else n_pass++;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle(5);
  endtask

  task automatic send_image_checked(input string tag, input bit ramp);
    arm();
    n_total++;
    if (busy !== 1'b1) $display("FAIL %s_busy_after_start: got %b required 1", tag, busy);
    else n_pass++;
    for (int i = 0; i < IMG; i++) begin
      send_byte(ramp ? 8'(i % 256) : 8'($urandom_range(0, 255)), 1'b1);
      idle($urandom_range(0, 20));
    end
    wait_done();
    n_total++;
    if (n_writes() !== IMG) $display("FAIL %s_write_count: got %0d required %0d", tag, n_writes(), IMG);
    else n_pass++;
    n_total++;
    if (img_mismatch() !== 0) $display("FAIL %s_image_data: mismatches %0d required 0", tag, img_mismatch());
    else n_pass++;
    n_total++;
    if (done_cnt - done_base !== 1) $display("FAIL %s_done_count: got %0d required 1", tag, done_cnt - done_base);
    else n_pass++;
    n_total++;
    if (done_cyc !== last_we_cyc + 1)
      $display("FAIL %s_done_timing: done at %0d required %0d", tag, done_cyc, last_we_cyc + 1);
    else n_pass++;
    n_total++;
    if (busy !== 1'b0) $display("FAIL %s_busy_after_done: got %b required 0", tag, busy);
    else n_pass++;
  endtask

  task automatic test_full_image();
    send_image_checked("img", 1'b1);
    n_total++;
    if (obs_addr[obs_base + IMG - 1] !== 10'(IMG - 1))
      $display("FAIL img_last_addr: got %0d required %0d", obs_addr[obs_base + IMG - 1], IMG - 1);
    else n_pass++;
  endtask

  task automatic test_frame_error();
    arm();
    send_byte(8'h5A, 1'b0);
    idle(BIT);
    send_byte(8'hA5, 1'b1);
    idle(10);
    n_total++;
    if (err_frame !== 1'b1) $display("FAIL frame_err_flag: got %b required 1", err_frame);
    else n_pass++;
    n_total++;
    if (n_writes() !== 1) $display("FAIL frame_write_count: got %0d required 1", n_writes());
    else n_pass++;
    n_total++;
    if (n_writes() == 1 && {obs_addr[obs_base], obs_data[obs_base]} !== {10'd0, 8'hA5})
      $display("FAIL frame_write: got addr %0d data %h required addr 0 data a5",
               obs_addr[obs_base], obs_data[obs_base]);
    else n_pass++;
    wait_timeout();
  endtask

  task automatic test_timeout();
    arm();
    n_total++;
    if (err_frame !== 1'b0) $display("FAIL timeout_start_clears_frame: got %b required 0", err_frame);
    else n_pass++;
    for (int i = 0; i < 10; i++) begin
      send_byte(8'($urandom_range(0, 255)), 1'b1);
      idle($urandom_range(0, 20));
    end
    idle(TIMEOUT - 100);
    n_total++;
    if (busy !== 1'b1) $display("FAIL timeout_not_early: busy %b required 1", busy);
    else n_pass++;
    idle(200);
    m_armed = 1'b0;
    n_total++;
    if ({err_timeout, busy} !== 2'b10) $display("FAIL timeout_flags: err_timeout,busy %b required 10", {err_timeout, busy});
    else n_pass++;
    n_total++;
    if (done_cnt !== done_base) $display("FAIL timeout_no_done: got %0d pulses required 0", done_cnt - done_base);
    else n_pass++;
    n_total++;
    if (img_mismatch() !== 0 || n_writes() !== 10)
      $display("FAIL timeout_writes: %0d writes, mismatches %0d required 10 and 0", n_writes(), img_mismatch());
    else n_pass++;
    arm();
    n_total++;
    if (err_timeout !== 1'b0) $display("FAIL timeout_cleared_by_start: got %b required 0", err_timeout);
    else n_pass++;
    send_byte(8'($urandom_range(0, 255)), 1'b1);
    idle(10);
    n_total++;
    if (img_mismatch() !== 0 || n_writes() !== 1)
      $display("FAIL timeout_restart_addr0: %0d writes, mismatches %0d required 1 and 0", n_writes(), img_mismatch());
    else n_pass++;
    wait_timeout();
  endtask

  task automatic test_glitch();
    arm();
    uart_rxd = 1'b0;
    repeat (BIT / 4) @(negedge clk);
    idle(3 * BIT);
    n_total++;
    if (n_writes() !== 0) $display("FAIL glitch_no_write: got %0d writes required 0", n_writes());
    else n_pass++;
    send_byte(8'($urandom_range(0, 255)), 1'b1);
    idle(10);
    n_total++;
    if (img_mismatch() !== 0 || n_writes() !== 1)
      $display("FAIL glitch_then_byte: %0d writes, mismatches %0d required 1 and 0", n_writes(), img_mismatch());
    else n_pass++;
    wait_timeout();
  endtask

  task automatic test_bytes_before_start();
    obs_base = obs_addr.size();
    for (int i = 0; i < 3; i++) begin
      send_byte(8'($urandom_range(0, 255)), 1'b1);
      idle(5);
    end
    n_total++;
    if (n_writes() !== 0) $display("FAIL idle_bytes_not_written: got %0d writes required 0", n_writes());
    else n_pass++;
    send_image_checked("pre", 1'b0);
  endtask

  task automatic test_reset_mid_image();
    arm();
    for (int i = 0; i < IMG / 2; i++) begin
      send_byte(8'($urandom_range(0, 255)), 1'b1);
      idle($urandom_range(0, 10));
    end
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'($urandom_range(0, 1)));
    rst = 1'b1;
    m_armed = 1'b0;
    #1;
    n_total++;
    if ({ram_we, ram_addr, ram_wdata, busy, done, err_timeout, err_frame} !== 23'd0)
      $display("FAIL midreset_outputs: got %b required all 0",
               {ram_we, ram_addr, ram_wdata, busy, done, err_timeout, err_frame});
    else n_pass++;
    repeat (3) @(negedge clk);
    uart_rxd = 1'b1;
    rst = 1'b0;
    idle(4 * BIT);
    n_total++;
    if (img_mismatch() !== 0 || n_writes() !== IMG / 2)
      $display("FAIL midreset_writes: %0d writes, mismatches %0d required %0d and 0",
               n_writes(), img_mismatch(), IMG / 2);
    else n_pass++;
    n_total++;
    if (done_cnt !== done_base) $display("FAIL midreset_no_done: got %0d pulses required 0", done_cnt - done_base);
    else n_pass++;
    send_image_checked("post", 1'b0);
  endtask

  initial begin
    test_reset();
    test_full_image();
    test_frame_error();
    test_timeout();
    test_glitch();
    test_bytes_before_start();
    test_reset_mid_image();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
